// File: rtl/pc_sequencer_if.sv
// ============================================================
// Interface : pc_sequencer_if
// Brief     : Control and status bundle of the PC sequencer
// Revision  : 1.0
// ============================================================
`default_nettype none

interface pc_sequencer_if;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] next_pc_o;
  logic        sel_branch_o;
  logic        flush_o;
  logic        pending_o;
  logic        misalign_o;
  logic [1:0]  state_o;

  modport master (
    output stall_i, branch_taken_i, branch_target_i, halt_i,
    input  pc_o, pc_plus4_o, next_pc_o, sel_branch_o, flush_o,
           pending_o, misalign_o, state_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i, halt_i,
    output pc_o, pc_plus4_o, next_pc_o, sel_branch_o, flush_o,
           pending_o, misalign_o, state_o
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================
// Module   : pc_sequencer
// Brief    : PC register with stall, deferred redirect, trap and halt
// Revision : 1.0
// ============================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_TRAP  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        flush_q, flush_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic [31:0] next_pc;
  logic        redirect;
  logic        active;

  always_comb begin
    pc_plus4     = pc_q + 32'd4;
    active       = (state_q == ST_RUN) || (state_q == ST_STALL);
    // A fresh request always beats a deferred one
    redirect     = active && (bus.branch_taken_i || pending_q);
    redirect_tgt = bus.branch_taken_i ? bus.branch_target_i : pend_tgt_q;
    next_pc      = redirect ? redirect_tgt : pc_plus4;

    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    pend_tgt_d = pend_tgt_q;
    flush_d    = 1'b0;

    case (state_q)
      ST_TRAP: begin
        state_d = ST_RUN;
        pc_d    = pc_plus4;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        if (bus.halt_i) begin
          state_d   = ST_HALT;
          pending_d = 1'b0;
        end else if (bus.stall_i) begin
          state_d = ST_STALL;
          if (bus.branch_taken_i) begin
            pending_d  = 1'b1;
            pend_tgt_d = bus.branch_target_i;
          end
        end else if (redirect && (redirect_tgt[1:0] != 2'b00)) begin
          state_d   = ST_TRAP;
          pc_d      = TRAP_VEC;
          pending_d = 1'b0;
          flush_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
          pc_d    = next_pc;
          if (redirect) begin
            pending_d = 1'b0;
            flush_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pending_q  <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      pend_tgt_q <= pend_tgt_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_plus4_o   = pc_plus4;
  assign bus.next_pc_o    = next_pc;
  assign bus.sel_branch_o = redirect;
  assign bus.flush_o      = flush_q;
  assign bus.pending_o    = pending_q;
  assign bus.misalign_o   = (state_q == ST_TRAP);
  assign bus.state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================
// Module   : tb_pc_sequencer
// Brief    : Directed scenarios plus random stimulus against a rule-level model
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0004;
  localparam logic [1:0]  M_RUN = 2'd0, M_STALL = 2'd1, M_TRAP = 2'd2, M_HALT = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model of architectural state: PC, mode, deferred redirect, flush for the coming cycle
  logic [31:0] m_pc, m_ptgt;
  logic [1:0]  m_st;
  logic        m_pend, m_flush;

  task automatic model_reset();
    m_pc = RESET_PC; m_st = M_RUN; m_pend = 1'b0; m_ptgt = 32'h0; m_flush = 1'b0;
  endtask

  task automatic model_edge();
    logic        want;
    logic [31:0] dest;
    want = bus.branch_taken_i || m_pend;
    dest = bus.branch_taken_i ? bus.branch_target_i : m_ptgt;
    m_flush = 1'b0;
    if (m_st == M_TRAP) begin
      m_pc = m_pc + 32'd4;
      m_st = M_RUN;
    end else if (m_st == M_HALT) begin
      m_st = M_HALT;
    end else if (bus.halt_i) begin
      m_st = M_HALT; m_pend = 1'b0;
    end else if (bus.stall_i) begin
      m_st = M_STALL;
      if (bus.branch_taken_i) begin m_pend = 1'b1; m_ptgt = bus.branch_target_i; end
    end else if (!want) begin
      m_pc = m_pc + 32'd4; m_st = M_RUN;
    end else if (dest % 4 != 0) begin
      m_pc = TRAP_VEC; m_st = M_TRAP; m_pend = 1'b0; m_flush = 1'b1;
    end else begin
      m_pc = dest; m_st = M_RUN; m_pend = 1'b0; m_flush = 1'b1;
    end
  endtask

  task automatic drive(input logic st, input logic bt, input logic [31:0] tgt, input logic h);
    bus.stall_i = st; bus.branch_taken_i = bt; bus.branch_target_i = tgt; bus.halt_i = h;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    model_reset();
    #2;
    n_checks++;
    if ({bus.pc_o, bus.state_o, bus.flush_o, bus.pending_o, bus.misalign_o} !== {RESET_PC, M_RUN, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_initial: got pc=%h st=%0d fl=%b pe=%b mis=%b, exp pc=%h st=0 all flags 0",
               bus.pc_o, bus.state_o, bus.flush_o, bus.pending_o, bus.misalign_o, RESET_PC);
    end
    #2 rst = 1'b0;
    cyc(); cyc();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({bus.pc_o, bus.state_o, bus.flush_o, bus.pending_o} !== {RESET_PC, M_RUN, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_midrun: got pc=%h st=%0d fl=%b pe=%b, exp pc=%h st=0",
               bus.pc_o, bus.state_o, bus.flush_o, bus.pending_o, RESET_PC);
    end
    #1 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_checks++;
      if ({bus.pc_o, bus.flush_o} !== {32'(4 * i), 1'b0}) begin
        n_fail++;
        $display("FAIL free_run_%0d: got pc=%h fl=%b, exp pc=%h fl=0", i, bus.pc_o, bus.flush_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    cyc();
    n_checks++;
    if (bus.pc_o !== 32'h10) begin
      n_fail++; $display("FAIL pre_redirect_pc: got %h exp 00000010", bus.pc_o);
    end
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    #1;
    n_checks++;
    if ({bus.sel_branch_o, bus.next_pc_o} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL redirect_select: got sel=%b next=%h exp sel=1 next=00000040", bus.sel_branch_o, bus.next_pc_o);
    end
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.flush_o, bus.state_o} !== {32'h40, 1'b1, M_RUN}) begin
      n_fail++; $display("FAIL redirect_apply: got pc=%h fl=%b st=%0d exp pc=00000040 fl=1 st=0", bus.pc_o, bus.flush_o, bus.state_o);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.flush_o} !== {32'h44, 1'b0}) begin
      n_fail++; $display("FAIL redirect_after: got pc=%h fl=%b exp pc=00000044 fl=0", bus.pc_o, bus.flush_o);
    end
  endtask

  task automatic test_stall_pending();
    drive(1'b0, 1'b1, 32'h20, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 32'h80, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.pending_o, bus.state_o, bus.flush_o} !== {32'h20, 1'b1, M_STALL, 1'b0}) begin
      n_fail++; $display("FAIL stall_latch: got pc=%h pe=%b st=%0d fl=%b exp pc=00000020 pe=1 st=1 fl=0",
                         bus.pc_o, bus.pending_o, bus.state_o, bus.flush_o);
    end
    drive(1'b1, 1'b1, 32'h90, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.pending_o, bus.flush_o, bus.sel_branch_o, bus.next_pc_o} !== {32'h20, 1'b1, 1'b0, 1'b1, 32'h90}) begin
      n_fail++; $display("FAIL stall_overwrite: got pc=%h pe=%b fl=%b sel=%b next=%h exp pc=00000020 pe=1 fl=0 sel=1 next=00000090",
                         bus.pc_o, bus.pending_o, bus.flush_o, bus.sel_branch_o, bus.next_pc_o);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.flush_o, bus.pending_o, bus.state_o} !== {32'h90, 1'b1, 1'b0, M_RUN}) begin
      n_fail++; $display("FAIL stall_release: got pc=%h fl=%b pe=%b st=%0d exp pc=00000090 fl=1 pe=0 st=0",
                         bus.pc_o, bus.flush_o, bus.pending_o, bus.state_o);
    end
  endtask

  task automatic test_fresh_beats_pending();
    drive(1'b1, 1'b1, 32'h90, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 32'hA0, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.pending_o, bus.flush_o} !== {32'hA0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fresh_beats_pending: got pc=%h pe=%b fl=%b exp pc=000000a0 pe=0 fl=1",
                         bus.pc_o, bus.pending_o, bus.flush_o);
    end
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b1, 32'h42, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.misalign_o, bus.flush_o, bus.state_o, bus.pending_o} !== {TRAP_VEC, 1'b1, 1'b1, M_TRAP, 1'b0}) begin
      n_fail++; $display("FAIL trap_enter: got pc=%h mis=%b fl=%b st=%0d pe=%b exp pc=%h mis=1 fl=1 st=2 pe=0",
                         bus.pc_o, bus.misalign_o, bus.flush_o, bus.state_o, bus.pending_o, TRAP_VEC);
    end
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.misalign_o, bus.flush_o, bus.state_o} !== {TRAP_VEC + 32'd4, 1'b0, 1'b0, M_RUN}) begin
      n_fail++; $display("FAIL trap_exit: got pc=%h mis=%b fl=%b st=%0d exp pc=%h mis=0 fl=0 st=0",
                         bus.pc_o, bus.misalign_o, bus.flush_o, bus.state_o, TRAP_VEC + 32'd4);
    end
  endtask

  task automatic test_wrap_halt();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.pc_plus4_o} !== {32'hFFFF_FFFC, 32'h0}) begin
      n_fail++; $display("FAIL wrap_plus4: got pc=%h p4=%h exp pc=fffffffc p4=00000000", bus.pc_o, bus.pc_plus4_o);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    n_checks++;
    if (bus.pc_o !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc: got %h exp 00000000", bus.pc_o);
    end
    drive(1'b0, 1'b1, 32'h40, 1'b1);
    cyc();
    n_checks++;
    if ({bus.pc_o, bus.state_o, bus.flush_o} !== {32'h0, M_HALT, 1'b0}) begin
      n_fail++; $display("FAIL halt_enter: got pc=%h st=%0d fl=%b exp pc=00000000 st=3 fl=0", bus.pc_o, bus.state_o, bus.flush_o);
    end
    drive(1'b1, 1'b1, 32'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({bus.pc_o, bus.state_o, bus.pending_o, bus.flush_o, bus.sel_branch_o} !== {32'h0, M_HALT, 3'b000}) begin
        n_fail++; $display("FAIL halt_hold_%0d: got pc=%h st=%0d pe=%b fl=%b sel=%b exp pc=0 st=3 flags 0",
                           i, bus.pc_o, bus.state_o, bus.pending_o, bus.flush_o, bus.sel_branch_o);
      end
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({bus.pc_o, bus.state_o} !== {RESET_PC, M_RUN}) begin
      n_fail++; $display("FAIL halt_reset: got pc=%h st=%0d exp pc=%h st=0", bus.pc_o, bus.state_o, RESET_PC);
    end
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    n_checks++;
    if (bus.pc_o !== RESET_PC + 32'd4) begin
      n_fail++; $display("FAIL post_halt_run: got %h exp %h", bus.pc_o, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_random();
    logic [101:0] got, exp;
    logic [31:0]  tgt;
    logic         exp_sel;
    logic [31:0]  exp_next;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({bus.pc_o, bus.state_o, bus.pending_o, bus.flush_o} !== {RESET_PC, M_RUN, 2'b00}) begin
          n_fail++; $display("FAIL rand_reset_%0d: got pc=%h st=%0d pe=%b fl=%b exp pc=%h st=0",
                             i, bus.pc_o, bus.state_o, bus.pending_o, bus.flush_o, RESET_PC);
        end
        #1 rst = 1'b0;
      end
      tgt = $urandom();
      if ($urandom_range(7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(31) == 0) tgt = 32'hFFFF_FFFC;
      drive(($urandom_range(9) < 3), ($urandom_range(3) == 0), tgt, ($urandom_range(63) == 0));
      #1;
      exp_sel  = (m_st == M_RUN || m_st == M_STALL) && (bus.branch_taken_i || m_pend);
      exp_next = exp_sel ? (bus.branch_taken_i ? bus.branch_target_i : m_ptgt) : m_pc + 32'd4;
      exp = {m_pc, m_pc + 32'd4, exp_next, exp_sel, m_flush, m_pend, (m_st == M_TRAP), m_st};
      got = {bus.pc_o, bus.pc_plus4_o, bus.next_pc_o, bus.sel_branch_o, bus.flush_o,
             bus.pending_o, bus.misalign_o, bus.state_o};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_cycle_%0d: got pc/p4/next/sel,fl,pe,mis,st=%h exp %h", i, got, exp);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall_pending();
    test_fresh_beats_pending();
    test_misalign();
    test_wrap_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
